// File: rtl/ysyx_22041211_mem_arbiter.sv
// Round-robin arbiter sharing the core memory port between instruction fetch and
// load/store, one outstanding transaction at a time, with a per-transaction timeout.
module ysyx_22041211_mem_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic                if_resp_valid,
  output logic [DATA_LEN-1:0] if_resp_data,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_LEN-1:0] ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_LEN-1:0] ls_wdata,
  input  logic [7:0]          ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_LEN-1:0] ls_resp_data,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [7:0]          mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_resp_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_LEN-1:0]   mem_addr_q, mem_addr_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [DATA_LEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [7:0]            mem_wmask_q, mem_wmask_d;
  logic                  if_resp_valid_q, if_resp_valid_d;
  logic [DATA_LEN-1:0]   if_resp_data_q, if_resp_data_d;
  logic                  if_resp_err_q, if_resp_err_d;
  logic                  ls_resp_valid_q, ls_resp_valid_d;
  logic [DATA_LEN-1:0]   ls_resp_data_q, ls_resp_data_d;
  logic                  ls_resp_err_q, ls_resp_err_d;

  logic if_win, ls_win, timeout_hit, finish, finish_err;
  logic [DATA_LEN-1:0] finish_data;

  // On a tie the master that did not win last time goes first.
  assign if_win = if_req_valid && (!ls_req_valid || (last_grant_q == GNT_LS));
  assign ls_win = ls_req_valid && !if_win;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  assign if_req_ready = rst && (state_q == IDLE) && if_win;
  assign ls_req_ready = rst && (state_q == IDLE) && ls_win;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    finish          = 1'b0;
    finish_err      = 1'b0;
    finish_data     = '0;
    case (state_q)
      IDLE: begin
        if (if_win || ls_win) begin
          grant_d         = ls_win ? GNT_LS : GNT_IF;
          last_grant_d    = ls_win ? GNT_LS : GNT_IF;
          cnt_d           = '0;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = ls_win ? ls_addr : if_addr;
          mem_wen_d       = ls_win ? ls_wen : 1'b0;
          mem_wdata_d     = ls_win ? ls_wdata : '0;
          mem_wmask_d     = ls_win ? ls_wmask : 8'h0F;
          state_d         = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_hit) begin
          finish          = 1'b1;
          finish_err      = 1'b1;
          mem_req_valid_d = 1'b0;
          state_d         = IDLE;
        end else if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CW'(1);
        // A response arriving on the timeout cycle still counts as a success.
        if (mem_resp_valid) begin
          finish      = 1'b1;
          finish_data = mem_resp_data;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if_resp_valid_d = finish && (grant_q == GNT_IF);
    if_resp_err_d   = finish && (grant_q == GNT_IF) && finish_err;
    if_resp_data_d  = (grant_q == GNT_IF) ? finish_data : '0;
    ls_resp_valid_d = finish && (grant_q == GNT_LS);
    ls_resp_err_d   = finish && (grant_q == GNT_LS) && finish_err;
    ls_resp_data_d  = (grant_q == GNT_LS) ? finish_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      grant_q         <= GNT_IF;
      last_grant_q    <= GNT_LS;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      if_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      if_resp_err_q   <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      ls_resp_data_q  <= '0;
      ls_resp_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      if_resp_valid_q <= if_resp_valid_d;
      if_resp_data_q  <= if_resp_data_d;
      if_resp_err_q   <= if_resp_err_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      ls_resp_data_q  <= ls_resp_data_d;
      ls_resp_err_q   <= ls_resp_err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_data  = if_resp_data_q;
  assign if_resp_err   = if_resp_err_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_data  = ls_resp_data_q;
  assign ls_resp_err   = ls_resp_err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/ysyx_22041211_mem_arbiter.md
Name: ysyx_22041211_mem_arbiter

Overview:
- Shares the single core memory port between the instruction fetch unit (IF, read-only) and the load/store unit (LS, read/write).
- Round-robin arbitration on simultaneous requests; one outstanding transaction at a time.
- Per-transaction timeout returns an error response so a hung slave cannot deadlock the core.
- Sits between the IF/LSU stages and the memory-side bridge that wraps the pmem read/write DPI calls.

Parameters:
- DATA_LEN, 32, data width.
- ADDR_LEN, 32, address width.
- TIMEOUT, 16, cycles allowed from slave-request issue to response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  ADDR_LEN  IF read address.
- if_resp_valid  out  1  IF response, one-cycle pulse.
- if_resp_data  out  DATA_LEN  IF read data.
- if_resp_err  out  1  IF transaction timed out.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_addr  in  ADDR_LEN  LS address.
- ls_wen  in  1  1 = write, 0 = read.
- ls_wdata  in  DATA_LEN  LS write data.
- ls_wmask  in  8  LS byte mask.
- ls_resp_valid  out  1  LS response, one-cycle pulse.
- ls_resp_data  out  DATA_LEN  LS read data.
- ls_resp_err  out  1  LS transaction timed out.
- mem_req_valid  out  1  request to slave.
- mem_req_ready  in  1  slave accepts request.
- mem_addr  out  ADDR_LEN  slave address.
- mem_wen  out  1  slave write enable.
- mem_wdata  out  DATA_LEN  slave write data.
- mem_wmask  out  8  slave byte mask.
- mem_resp_valid  in  1  slave response.
- mem_resp_data  in  DATA_LEN  slave read data.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- Registered reset values: all registered outputs 0, counter 0, last_grant = LS (so the first tie goes to IF).
- IDLE, winner selection:
  - Only one valid: that master wins.
  - Both valid: the master not equal to last_grant wins.
  - Winner's req_ready = 1 combinationally, only in IDLE, only for the winner; it is 0 in all other states.
- IDLE, on acceptance:
  - Latch addr, wen, wdata and wmask into the mem_* registers. IF forces wen = 0, wdata = 0, wmask = 8'h0F.
  - Record the winner in grant and last_grant; clear the counter; go to REQ.
- REQ:
  - mem_req_valid = 1; mem_* fields stay stable.
  - On mem_req_ready, drop mem_req_valid next cycle and go to RESP.
- RESP: on mem_resp_valid:
  - Next cycle, the granted master's resp_valid = 1 for exactly one cycle, resp_data = mem_resp_data, resp_err = 0.
  - Go to IDLE.
  - A write also produces a resp_valid pulse; its data is don't-care.
- Latency: accept at cycle T; mem_req_valid rises at T+1. With slave ready at T+1 and response at T+2, the master's resp_valid rises at T+3.
- Back-to-back: a new request can be accepted in the cycle resp_valid is high, because the state is already IDLE.
- Timeout (TIMEOUT > 0):
  - Counter increments every cycle in REQ or RESP.
  - If it reaches TIMEOUT without the state leaving RESP via a response, the next cycle gives the granted master resp_valid = 1, resp_err = 1, resp_data = 0.
  - mem_req_valid drops; state goes to IDLE.
  - If timeout and mem_resp_valid coincide, the response wins (err = 0).
- A mem_resp_valid arriving in IDLE or REQ is ignored.
- Masters must hold req_valid and fields stable until ready. A master that drops valid before ready loses the request; no error is flagged.
- The non-granted master's resp_* stays 0.
- Reset asserted mid-transaction: immediate return to IDLE, outputs 0, transaction dropped, no response issued.

Test Plan:
- Single IF read, addr 0x80000000, slave ready at once, response data 0x00100073 two cycles later → if_req_ready pulse at T; mem_wmask = 8'h0F, mem_wen = 0; if_resp_valid at T+3 with data 0x00100073.
- IF and LS request simultaneously from reset → IF granted first. LS held valid → granted in IDLE after the IF response. A third tie → LS loses to IF, confirming alternation.
- LS write addr 0x80001000, wdata 0xDEADBEEF, wmask 8'h03 → mem_* carry exactly these values; ls_resp_valid pulse, err = 0.
- TIMEOUT = 4, slave never responds → ls_resp_err = 1 with data 0 after the count expires; busy falls. A later stray mem_resp_valid produces no resp pulse.
- Slave holds mem_req_ready low for 3 cycles → mem_req_valid and all fields stable throughout; no acceptance of the other master meanwhile.
- Assert rst = 0 while in RESP → all outputs 0 asynchronously. After release, IF wins the first tie; no stale response is emitted.
